// File: rtl/program_loader_pkg.sv
// rtl/program_loader_pkg.sv - shared types and constants for the boot program loader
package program_loader_pkg;

  // Loader sequencing states
  typedef enum logic [3:0] {
    S_IDLE,
    S_HDR_BASE,
    S_HDR_COUNT,
    S_LOAD,
    S_CHECK,
    S_VERIFY_RD,
    S_VERIFY_WAIT,
    S_VERIFY_ACC,
    S_DONE,
    S_ERROR
  } state_t;

  localparam logic [1:0] ERR_NONE   = 2'd0;
  localparam logic [1:0] ERR_HDR    = 2'd1;
  localparam logic [1:0] ERR_SUM    = 2'd2;
  localparam logic [1:0] ERR_VERIFY = 2'd3;

  // Header words carry a 28-bit field in a 32-bit word; the top nibble must be zero
  localparam int HDR_WORD_BITS  = 32;
  localparam int HDR_FIELD_BITS = 28;

  function automatic logic hdr_ok(input logic [HDR_WORD_BITS-1:0] word);
    return word[HDR_WORD_BITS-1:HDR_FIELD_BITS] == '0;
  endfunction

endpackage

// File: rtl/loader_checksum.sv
// rtl/loader_checksum.sv - clear/accumulate sum register, wraps modulo 2^WIDTH
module loader_checksum #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             accumulate,
  input  logic [WIDTH-1:0] value,
  output logic [WIDTH-1:0] sum
);

  // Clear has priority so a new load always starts from zero
  always_ff @(posedge clock) begin
    if (reset || clear) sum <= '0;
    else if (accumulate) sum <= sum + value;
  end

endmodule

// File: rtl/program_loader.sv
// rtl/program_loader.sv - framed stream to RAM loader with optional read-back verify
module program_loader
  import program_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 28,
  parameter int DATA_WIDTH = 32,
  parameter int VERIFY     = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic                  ram_cs,
  output logic                  ram_we,
  output logic                  ram_oe,
  output logic                  busy,
  output logic                  done,
  output logic [1:0]            err_code,
  output logic                  cpu_start,
  output logic [ADDR_WIDTH-1:0] start_pc
);

  state_t state, next_state;

  logic                  accept, start_take;
  logic [ADDR_WIDTH-1:0] base_q, count_q, idx_q, idx_next;
  logic [DATA_WIDTH-1:0] stream_sum, verify_sum;

  logic                  in_ready_d, busy_d, done_d, cpu_start_d;
  logic                  cs_d, we_d, oe_d;
  logic [ADDR_WIDTH-1:0] addr_d, pc_d;
  logic [DATA_WIDTH-1:0] wdata_d;
  logic [1:0]            err_d;

  assign accept     = in_valid && in_ready;
  assign start_take = start && (state == S_IDLE || state == S_DONE || state == S_ERROR);
  assign idx_next   = idx_q + ADDR_WIDTH'(1);

  loader_checksum #(.WIDTH(DATA_WIDTH)) u_stream_sum (
    .clock      (clock),
    .reset      (reset),
    .clear      (start_take),
    .accumulate (state == S_LOAD && accept),
    .value      (in_data),
    .sum        (stream_sum)
  );

  loader_checksum #(.WIDTH(DATA_WIDTH)) u_verify_sum (
    .clock      (clock),
    .reset      (reset),
    .clear      (start_take),
    .accumulate (state == S_VERIFY_WAIT),
    .value      (ram_rdata),
    .sum        (verify_sum)
  );

  // State register
  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  // Next-state decode; VERIFY_ACC doubles as the loop head so an empty image still compares
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE, S_DONE, S_ERROR: next_state = start ? S_HDR_BASE : S_IDLE;
      S_HDR_BASE:    if (accept) next_state = hdr_ok(in_data) ? S_HDR_COUNT : S_ERROR;
      S_HDR_COUNT:   if (accept) begin
                       if (!hdr_ok(in_data))                   next_state = S_ERROR;
                       else if (in_data[ADDR_WIDTH-1:0] == '0) next_state = S_CHECK;
                       else                                    next_state = S_LOAD;
                     end
      S_LOAD:        if (accept && idx_next == count_q) next_state = S_CHECK;
      S_CHECK:       if (accept) begin
                       if (in_data != stream_sum) next_state = S_ERROR;
                       else if (VERIFY != 0)      next_state = S_VERIFY_ACC;
                       else                       next_state = S_DONE;
                     end
      S_VERIFY_RD:   next_state = S_VERIFY_WAIT;
      S_VERIFY_WAIT: next_state = S_VERIFY_ACC;
      S_VERIFY_ACC:  if (idx_q == count_q) next_state = (verify_sum == stream_sum) ? S_DONE : S_ERROR;
                     else                  next_state = S_VERIFY_RD;
      default:       next_state = S_IDLE;
    endcase
  end

  // Header capture and the word index shared by the load and verify passes
  always_ff @(posedge clock) begin
    if (reset) begin
      base_q  <= '0;
      count_q <= '0;
      idx_q   <= '0;
    end else begin
      case (state)
        S_HDR_BASE:    if (accept) base_q <= in_data[ADDR_WIDTH-1:0];
        S_HDR_COUNT:   if (accept) begin
                         count_q <= in_data[ADDR_WIDTH-1:0];
                         idx_q   <= '0;
                       end
        S_LOAD:        if (accept) idx_q <= idx_next;
        S_CHECK:       if (accept) idx_q <= '0;
        S_VERIFY_WAIT: idx_q <= idx_next;
        default:       ;
      endcase
    end
  end

  // Next values for every registered output
  always_comb begin
    in_ready_d  = next_state inside {S_HDR_BASE, S_HDR_COUNT, S_LOAD, S_CHECK};
    busy_d      = !(next_state inside {S_IDLE, S_DONE, S_ERROR});
    cs_d        = 1'b0;
    we_d        = 1'b0;
    oe_d        = 1'b1;
    addr_d      = ram_addr;
    wdata_d     = ram_wdata;
    done_d      = done;
    err_d       = err_code;
    cpu_start_d = 1'b0;
    pc_d        = start_pc;
    if (start_take) begin
      done_d = 1'b0;
      err_d  = ERR_NONE;
    end
    if (state == S_LOAD && accept) begin
      cs_d    = 1'b1;
      we_d    = 1'b1;
      oe_d    = 1'b0;
      addr_d  = base_q + idx_q;
      wdata_d = in_data;
    end
    if (next_state == S_VERIFY_RD) begin
      cs_d   = 1'b1;
      addr_d = base_q + idx_q;
    end
    if (next_state == S_DONE) begin
      done_d      = 1'b1;
      cpu_start_d = 1'b1;
      pc_d        = base_q;
    end
    if (next_state == S_ERROR) begin
      done_d = 1'b0;
      case (state)
        S_CHECK:      err_d = ERR_SUM;
        S_VERIFY_ACC: err_d = ERR_VERIFY;
        default:      err_d = ERR_HDR;
      endcase
    end
  end

  // Output registers
  always_ff @(posedge clock) begin
    if (reset) begin
      in_ready  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cpu_start <= 1'b0;
      ram_cs    <= 1'b0;
      ram_we    <= 1'b0;
      ram_oe    <= 1'b1;
      ram_addr  <= '0;
      ram_wdata <= '0;
      start_pc  <= '0;
      err_code  <= ERR_NONE;
    end else begin
      in_ready  <= in_ready_d;
      busy      <= busy_d;
      done      <= done_d;
      cpu_start <= cpu_start_d;
      ram_cs    <= cs_d;
      ram_we    <= we_d;
      ram_oe    <= oe_d;
      ram_addr  <= addr_d;
      ram_wdata <= wdata_d;
      start_pc  <= pc_d;
      err_code  <= err_d;
    end
  end

endmodule

// File: doc/program_loader.md
# program_loader

Boot-time program loader that sits directly upstream of the accumulator CPU and its `single_port_sync_ram_large` memory. It accepts a framed word stream (base address, word count, payload, checksum) over a valid/ready handshake and writes the payload into RAM. It then optionally reads the image back to verify it, and finally hands the CPU a one-cycle start pulse with the entry PC. It replaces the hand-written RAM preload sequence currently done ahead of the fetch loop.

## Interface
- `ADDR_WIDTH`, 28: RAM word-address width.
- `DATA_WIDTH`, 32: word width.
- `VERIFY`, 1: 1 enables the read-back checksum pass after load; 0 skips it.

Ports:
- `clock` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: one-cycle request to begin a load; ignored while `busy`.
- `in_valid` in 1: stream word valid.
- `in_ready` out 1: loader accepts the word this cycle.
- `in_data` in 32: stream word.
- `ram_addr` out 28: RAM address (MAR).
- `ram_wdata` out 32: write data, driven onto the RAM data bus while `ram_oe`=0.
- `ram_rdata` in 32: RAM read data.
- `ram_cs`, `ram_we`, `ram_oe` out 1 each: RAM chip select, write enable, output enable.
- `busy` out 1: load in progress.
- `done` out 1: level; last load succeeded; cleared by next `start`.
- `err_code` out 2: 0 none, 1 bad header, 2 stream checksum mismatch, 3 read-back mismatch.
- `cpu_start` out 1: one-cycle pulse on success.
- `start_pc` out 28: entry PC = base address; valid while `done`.

## Operation
- Stream frame:
  - word0: base address. Bits [31:28] must be 0, else `err_code`=1.
  - word1: count. Bits [31:28] must be 0, else `err_code`=1.
  - count payload words.
  - one checksum word = sum of payload mod 2^32.
- FSM states: IDLE -> HDR_BASE -> HDR_COUNT -> LOAD -> CHECK -> (VERIFY_RD -> VERIFY_WAIT -> VERIFY_ACC)* -> DONE; any failure -> ERROR. DONE and ERROR return to IDLE; outputs `done`, `err_code` and `start_pc` hold there until the next `start`.
- `in_ready`=1 only in HDR_BASE, HDR_COUNT, LOAD and CHECK. Every other state holds it at 0.
- LOAD:
  - Each accepted beat writes to `base + idx`, address arithmetic mod 2^28 (wraps from 0xFFFFFFF to 0).
  - 32-bit running sum, wraps.
- count=0: LOAD is skipped and CHECK expects checksum 0.
- CHECK: accepts one word and compares it to the running sum. Mismatch -> ERROR with code 2; RAM keeps the words already written.
- Verify pass, one word at a time:
  - Issue a read (`cs`=1, `we`=0, `oe`=1).
  - Wait one cycle.
  - Add `ram_rdata` to a second sum.
  - After count words, compare the two sums; mismatch -> code 3.
- `VERIFY`=0: CHECK success goes straight to DONE.
- DONE: `done`=1, `start_pc`=base, `cpu_start` pulses for exactly one cycle on DONE entry.
- ERROR: `done`=0, `cpu_start` never asserted.
- `start` while `busy`=1 is ignored.
- `start` and `reset` in the same cycle: reset wins.
- Reset mid-load: FSM returns to IDLE and the RAM contents written so far are left in place.

## Timing
- Reset values:
  - `in_ready`, `busy`, `done`, `cpu_start`, `ram_cs`, `ram_we` = 0.
  - `ram_oe`=1.
  - `ram_addr`, `ram_wdata`, `start_pc` = 0.
  - `err_code`=0.
- All outputs are registered.
- `start` sampled at edge E -> `busy`=1 and `in_ready`=1 from E+1.
- Write path:
  - A beat is accepted at edge E when `in_valid` and `in_ready` are both 1.
  - Cycle after E: `ram_cs`=1, `ram_we`=1, `ram_oe`=0, `ram_addr`/`ram_wdata` valid.
  - RAM writes at E+1.
- Back-to-back beats give one write per cycle.
- Outside a write or read cycle, `ram_cs`, `ram_we` = 0 and `ram_oe`=1.
- Verify: 3 cycles per word.
  - The read address is presented in cycle R.
  - `ram_rdata` is sampled at the end of R+1.
- Latency from the checksum beat to `cpu_start`:
  - `VERIFY`=0: 1 cycle.
  - `VERIFY`=1: 3·count+2 cycles.

## Structure
- Package `program_loader_pkg`:
  - state enum;
  - `err_code` constants `ERR_NONE`, `ERR_HDR`, `ERR_SUM`, `ERR_VERIFY`;
  - header field widths.
- Sub-module `loader_checksum`: a 32-bit clear/accumulate register. It is instantiated twice, once for the stream sum and once for the read-back sum.

## Test plan
- Basic load with verify:
  - Stimulus: `start`; stream 0x100, 2, 0x20000113, 0x00000111, 0x20000224.
  - Response: RAM[0x100]=0x20000113, RAM[0x101]=0x00000111, `done`=1, `start_pc`=0x100, `err_code`=0, `cpu_start` pulses exactly once.
- Bad checksum:
  - Stimulus: same frame with checksum 0x20000225.
  - Response: `err_code`=2, `done`=0, no `cpu_start`, RAM[0x100..0x101] written.
- Bad header:
  - Stimulus: base 0x10000100.
  - Response: `err_code`=1 right after word0 is accepted, no RAM writes, no `cpu_start`.
- Address wrap and empty load:
  - Stimulus A: base 0xFFFFFFF, count 2.
  - Response A: words land at 0xFFFFFFF and 0x0000000.
  - Stimulus B: count 0 with checksum 0.
  - Response B: `done`=1, no RAM writes.
- Read-back failure:
  - Stimulus: bench corrupts RAM[0x101] between load and verify.
  - Response: `err_code`=3, no `cpu_start`.
- Throttling and reset:
  - Stimulus: `in_valid` toggled every other cycle; `start` re-asserted mid-load; `reset` asserted mid-load.
  - Response: writes occur only on handshakes; re-`start` ignored; after reset all outputs at reset values and the next `start` loads correctly.
